// File: rtl/fifo_write_port_arbiter.sv
// Packet-granular round-robin arbiter sharing one asynchronous-FIFO write port among requesters.
// Optional grant watchdog is built when FIFO_WRITE_PORT_ARBITER_WATCHDOG_EN is defined.
module fifo_write_port_arbiter #(
    parameter int REQUESTER_COUNT = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int WATCHDOG_CYCLES = 256
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [REQUESTER_COUNT-1:0]            request,
    input  logic [REQUESTER_COUNT*DATA_WIDTH-1:0] request_data,
    input  logic [REQUESTER_COUNT-1:0]            request_last,
    input  logic                                  fifo_full,
    output logic [REQUESTER_COUNT-1:0]            grant,
    output logic [REQUESTER_COUNT-1:0]            accept,
    output logic                                  fifo_write_enable,
    output logic [DATA_WIDTH-1:0]                 fifo_write_data,
    output logic [$clog2(REQUESTER_COUNT)-1:0]    active_index,
    output logic                                  busy,
    output logic                                  watchdog_expired
);

    localparam int INDEX_WIDTH = $clog2(REQUESTER_COUNT);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [INDEX_WIDTH-1:0]     rr_ptr;
    logic [INDEX_WIDTH-1:0]     rr_next;
    logic [INDEX_WIDTH-1:0]     index_next;
    logic [REQUESTER_COUNT-1:0] grant_next;
    logic [INDEX_WIDTH-1:0]     winner;
    logic [INDEX_WIDTH-1:0]     candidate;
    logic                       winner_found;
    logic                       xfer;
    logic                       wd_force;

    if (REQUESTER_COUNT < 2 || WATCHDOG_CYCLES < 2) begin : g_param_check
        $error("fifo_write_port_arbiter: REQUESTER_COUNT and WATCHDOG_CYCLES must both be at least 2");
    end

    // Search upward from rr_ptr with wrap; the first requesting index wins.
    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        candidate    = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            candidate = INDEX_WIDTH'((int'(rr_ptr) + i) % REQUESTER_COUNT);
            if (!winner_found && request[candidate]) begin
                winner_found = 1'b1;
                winner       = candidate;
            end
        end
    end

    assign busy              = (state == GRANTED);
    assign xfer              = busy && request[active_index] && !fifo_full;
    assign fifo_write_enable = xfer;
    assign accept            = grant & {REQUESTER_COUNT{xfer}};
    assign fifo_write_data   = request_data[active_index*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_next = state;
        index_next = active_index;
        rr_next    = rr_ptr;
        grant_next = grant;
        case (state)
            IDLE: begin
                if (winner_found) begin
                    state_next         = GRANTED;
                    index_next         = winner;
                    rr_next            = (winner == INDEX_WIDTH'(REQUESTER_COUNT - 1)) ? '0 : winner + 1'b1;
                    grant_next         = '0;
                    grant_next[winner] = 1'b1;
                end
            end
            GRANTED: begin
                if ((xfer && request_last[active_index]) || wd_force) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // NOTE: reset is synchronous and active-low, so it is only observed at a clock edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            active_index <= '0;
            rr_ptr       <= '0;
            grant        <= '0;
        end else begin
            state        <= state_next;
            active_index <= index_next;
            rr_ptr       <= rr_next;
            grant        <= grant_next;
        end
    end

`ifdef FIFO_WRITE_PORT_ARBITER_WATCHDOG_EN
    localparam int WD_WIDTH = $clog2(WATCHDOG_CYCLES);

    logic [WD_WIDTH-1:0] wd_count;
    logic                wd_expired_q;

    // Counts only granted cycles where the owner has no beat; a full-FIFO stall keeps request high.
    assign wd_force = busy && !request[active_index] &&
                      (wd_count == WD_WIDTH'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wd_count     <= '0;
            wd_expired_q <= 1'b0;
        end else begin
            wd_expired_q <= wd_force;
            if (!busy || request[active_index] || wd_force) begin
                wd_count <= '0;
            end else begin
                wd_count <= wd_count + 1'b1;
            end
        end
    end

    assign watchdog_expired = wd_expired_q;
`else
    assign wd_force         = 1'b0;
    assign watchdog_expired = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_port_arbiter.sv
// Directed self-checking bench for fifo_write_port_arbiter (4 requesters, 16-bit beats, watchdog limit 8).
module tb_fifo_write_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int WD = 8;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    request;
    logic [N*DW-1:0] request_data;
    logic [N-1:0]    request_last;
    logic            fifo_full;
    logic [N-1:0]    grant;
    logic [N-1:0]    accept;
    logic            fifo_write_enable;
    logic [DW-1:0]   fifo_write_data;
    logic [1:0]      active_index;
    logic            busy;
    logic            watchdog_expired;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_write_port_arbiter #(
        .REQUESTER_COUNT(N),
        .DATA_WIDTH     (DW),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .request          (request),
        .request_data     (request_data),
        .request_last     (request_last),
        .fifo_full        (fifo_full),
        .grant            (grant),
        .accept           (accept),
        .fifo_write_enable(fifo_write_enable),
        .fifo_write_data  (fifo_write_data),
        .active_index     (active_index),
        .busy             (busy),
        .watchdog_expired (watchdog_expired)
    );

    always #5 clock = ~clock;

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DW-1:0] value);
        request_data[idx*DW +: DW] = value;
    endtask

    task automatic apply_reset();
        reset_n      = 1'b0;
        request      = '0;
        request_last = '0;
        fifo_full    = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        request_data = '0;
        set_data(0, 16'h1234);
        set_data(1, 16'h5678);
        set_data(2, 16'h9ABC);
        set_data(3, 16'hDEF0);
        request      = '0;
        request_last = '0;
        fifo_full    = 1'b0;
        reset_n      = 1'b0;
        tick();
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (active_index !== 2'd0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", active_index); end
        n_checks++; if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
        n_checks++; if (accept !== 4'b0000 || fifo_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: accept=%b we=%b want 0000/0", accept, fifo_write_enable); end
        n_checks++; if (fifo_write_data !== 16'h1234) begin n_fail++; $display("FAIL reset_data: got %h want 1234", fifo_write_data); end
        n_checks++; if (watchdog_expired !== 1'b0) begin n_fail++; $display("FAIL reset_watchdog: got %b want 0", watchdog_expired); end
        reset_n = 1'b1;
    endtask

    task automatic test_three_beat_packet();
        logic [DW-1:0] beats [3] = '{16'h00A1, 16'h00A2, 16'h00A3};
        request = 4'b0010;
        set_data(1, beats[0]);
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL pkt_latency: got %b want 0000", grant); end
        tick();
        n_checks++; if (grant !== 4'b0010 || busy !== 1'b1 || active_index !== 2'd1) begin n_fail++; $display("FAIL pkt_grant: grant=%b busy=%b idx=%0d want 0010/1/1", grant, busy, active_index); end
        for (int b = 0; b < 3; b++) begin
            set_data(1, beats[b]);
            request_last[1] = (b == 2);
            #1;
            n_checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== beats[b] || accept !== 4'b0010) begin n_fail++; $display("FAIL pkt_beat%0d: we=%b data=%h accept=%b want 1/%h/0010", b, fifo_write_enable, fifo_write_data, accept, beats[b]); end
            tick();
        end
        request      = '0;
        request_last = '0;
        #1;
        n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL pkt_release: busy=%b grant=%b want 0/0000", busy, grant); end
        n_checks++; if (dut.rr_ptr !== 2'd2) begin n_fail++; $display("FAIL pkt_rr_ptr: got %0d want 2", dut.rr_ptr); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_grant [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        int           exp_idx   [9] = '{0, -1, 1, -1, 2, -1, 3, -1, 0};
        apply_reset();
        for (int i = 0; i < N; i++) set_data(i, DW'(16'h00B0 + i));
        request      = 4'b1111;
        request_last = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick();
            n_checks++; if (grant !== exp_grant[k]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, exp_grant[k]); end
            if (exp_idx[k] >= 0) begin
                n_checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== DW'(16'h00B0 + exp_idx[k])) begin n_fail++; $display("FAIL rr_data[%0d]: we=%b data=%h want 1/%h", k, fifo_write_enable, fifo_write_data, DW'(16'h00B0 + exp_idx[k])); end
            end
        end
        tick();
        request      = '0;
        request_last = '0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_fifo_full_stall();
        request = 4'b0001;
        set_data(0, 16'h00C0);
        tick();
        n_checks++; if (grant !== 4'b0001 || fifo_write_enable !== 1'b1 || fifo_write_data !== 16'h00C0) begin n_fail++; $display("FAIL stall_first: grant=%b we=%b data=%h want 0001/1/00c0", grant, fifo_write_enable, fifo_write_data); end
        tick();
        set_data(0, 16'h00C1);
        request_last = 4'b0001;
        fifo_full    = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_checks++; if (fifo_write_enable !== 1'b0 || accept !== 4'b0000 || grant !== 4'b0001) begin n_fail++; $display("FAIL stall_cycle%0d: we=%b accept=%b grant=%b want 0/0000/0001", s, fifo_write_enable, accept, grant); end
            tick();
        end
        fifo_full = 1'b0;
        #1;
        n_checks++; if (fifo_write_enable !== 1'b1 || accept !== 4'b0001 || fifo_write_data !== 16'h00C1) begin n_fail++; $display("FAIL stall_resume: we=%b accept=%b data=%h want 1/0001/00c1", fifo_write_enable, accept, fifo_write_data); end
        tick();
        request      = '0;
        request_last = '0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_release: busy=%b want 0", busy); end
    endtask

    task automatic test_no_preempt();
        request = 4'b0010;
        set_data(1, 16'h00D0);
        tick();
        request = 4'b1010;
        set_data(3, 16'h00E0);
        request_last[3] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_data(1, DW'(16'h00D0 + b));
            request_last[1] = (b == 2);
            #1;
            n_checks++; if (accept !== 4'b0010 || grant !== 4'b0010) begin n_fail++; $display("FAIL preempt_beat%0d: accept=%b grant=%b want 0010/0010", b, accept, grant); end
            tick();
        end
        request      = 4'b1000;
        request_last = 4'b1000;
        #1;
        n_checks++; if (grant !== 4'b0000 || accept[3] !== 1'b0) begin n_fail++; $display("FAIL preempt_gap: grant=%b accept3=%b want 0000/0", grant, accept[3]); end
        tick();
        n_checks++; if (grant !== 4'b1000 || accept !== 4'b1000 || fifo_write_data !== 16'h00E0) begin n_fail++; $display("FAIL preempt_next: grant=%b accept=%b data=%h want 1000/1000/00e0", grant, accept, fifo_write_data); end
        tick();
        request      = '0;
        request_last = '0;
    endtask

    task automatic test_watchdog();
        request = 4'b0100;
        set_data(2, 16'h00F0);
        tick();
        request = '0;
        for (int c = 0; c < WD; c++) begin
            #1;
            n_checks++; if (grant !== 4'b0100 || watchdog_expired !== 1'b0) begin n_fail++; $display("FAIL wd_hold%0d: grant=%b expired=%b want 0100/0", c, grant, watchdog_expired); end
            tick();
        end
`ifdef FIFO_WRITE_PORT_ARBITER_WATCHDOG_EN
        n_checks++; if (grant !== 4'b0000 || busy !== 1'b0 || watchdog_expired !== 1'b1) begin n_fail++; $display("FAIL wd_fire: grant=%b busy=%b expired=%b want 0000/0/1", grant, busy, watchdog_expired); end
        tick();
        n_checks++; if (watchdog_expired !== 1'b0) begin n_fail++; $display("FAIL wd_pulse_width: expired=%b want 0", watchdog_expired); end
`else
        for (int c = 0; c < 20; c++) begin
            n_checks++; if (grant !== 4'b0100 || watchdog_expired !== 1'b0) begin n_fail++; $display("FAIL wd_disabled%0d: grant=%b expired=%b want 0100/0", c, grant, watchdog_expired); end
            tick();
        end
        request      = 4'b0100;
        request_last = 4'b0100;
        #1;
        n_checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== 16'h00F0) begin n_fail++; $display("FAIL wd_late_beat: we=%b data=%h want 1/00f0", fifo_write_enable, fifo_write_data); end
        tick();
        request      = '0;
        request_last = '0;
`endif
    endtask

    task automatic test_reset_mid_packet();
        request = 4'b0010;
        set_data(1, 16'h0011);
        tick();
        tick();
        set_data(1, 16'h0012);
        #1;
        n_checks++; if (fifo_write_enable !== 1'b1 || fifo_write_data !== 16'h0012) begin n_fail++; $display("FAIL midrst_beat2: we=%b data=%h want 1/0012", fifo_write_enable, fifo_write_data); end
        tick();
        set_data(1, 16'h0013);
        reset_n = 1'b0;
        tick();
        n_checks++; if (grant !== 4'b0000 || busy !== 1'b0 || dut.rr_ptr !== 2'd0 || active_index !== 2'd0) begin n_fail++; $display("FAIL midrst_state: grant=%b busy=%b rr=%0d idx=%0d want 0000/0/0/0", grant, busy, dut.rr_ptr, active_index); end
        reset_n      = 1'b1;
        request      = 4'b0110;
        request_last = 4'b0110;
        tick();
        n_checks++; if (grant !== 4'b0010 || active_index !== 2'd1) begin n_fail++; $display("FAIL midrst_rearb: grant=%b idx=%0d want 0010/1", grant, active_index); end
        tick();
        request      = '0;
        request_last = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_three_beat_packet();
        test_round_robin();
        test_fifo_full_stall();
        test_no_preempt();
        test_watchdog();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
